imem_loader: RTL and testbench

//  Byte-stream program loader: the write side of the instruction memory the CPU fetches from.

---
 rtl/imem_loader_pkg.sv | 20 ++
 rtl/imem_loader_fsm.sv | 101 ++++++++++
 rtl/imem_loader.sv | 69 ++++++
 tb/tb_imem_loader.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory program loader.
// Loader state encoding and default frame parameters.
package imem_loader_pkg;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LEN_LO  = 3'd1,
    S_LEN_HI  = 3'd2,
    S_DATA_LO = 3'd3,
    S_DATA_HI = 3'd4,
    S_CHK     = 3'd5,
    S_DONE    = 3'd6,
    S_ERR     = 3'd7
  } state_t;

  localparam logic [7:0] DEF_SYNC      = 8'hA5;
  localparam int         DEF_MAX_WORDS = 256;
  localparam int         DEF_ADDR_W    = 16;

endpackage

// File: rtl/imem_loader_fsm.sv
// Frame parser: state, length, word index and running checksum.
// Raises wr_o on the accepted hi byte; the top registers the write.
module loader_fsm
  import imem_loader_pkg::*;
#(
  parameter logic [7:0] SYNC_BYTE = DEF_SYNC,
  parameter int         MAX_WORDS = DEF_MAX_WORDS,
  parameter int         IDX_W     = 15
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [7:0]       byte_i,
  input  logic             acc_i,
  output logic             wr_o,
  output logic [IDX_W-1:0] idx_o,
  output logic [7:0]       lo_o,
  output logic             done_o,
  output logic             error_o,
  output logic             hold_o
);

  state_t      state_q, state_d;
  logic [15:0] len_q, len_d;
  logic [15:0] idx_q, idx_d;
  logic [7:0]  chk_q, chk_d;
  logic [7:0]  lo_q, lo_d;
  logic [15:0] len_w;

  assign len_w   = {byte_i, len_q[7:0]};
  assign idx_o   = idx_q[IDX_W-1:0];
  assign lo_o    = lo_q;
  assign done_o  = (state_q == S_DONE);
  assign error_o = (state_q == S_ERR);
  assign hold_o  = (state_q != S_DONE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      len_q   <= '0;
      idx_q   <= '0;
      chk_q   <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      idx_q   <= idx_d;
      chk_q   <= chk_d;
      lo_q    <= lo_d;
    end
  end

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    idx_d   = idx_q;
    chk_d   = chk_q;
    lo_d    = lo_q;
    wr_o    = 1'b0;
    if (acc_i) begin
      unique case (state_q)
        S_IDLE, S_DONE, S_ERR: begin
          if (byte_i == SYNC_BYTE) state_d = S_LEN_LO;
        end
        S_LEN_LO: begin
          len_d[7:0] = byte_i;
          state_d    = S_LEN_HI;
        end
        S_LEN_HI: begin
          len_d[15:8] = byte_i;
          if (len_w == '0 || len_w > 16'(MAX_WORDS)) begin
            state_d = S_ERR;
          end else begin
            idx_d   = '0;
            chk_d   = '0;
            state_d = S_DATA_LO;
          end
        end
        S_DATA_LO: begin
          lo_d    = byte_i;
          chk_d   = chk_q ^ byte_i;
          state_d = S_DATA_HI;
        end
        S_DATA_HI: begin
          chk_d = chk_q ^ byte_i;
          wr_o  = 1'b1;
          if (idx_q + 16'd1 == len_q) begin
            state_d = S_CHK;
          end else begin
            idx_d   = idx_q + 16'd1;
            state_d = S_DATA_LO;
          end
        end
        S_CHK: begin
          state_d = (byte_i == chk_q) ? S_DONE : S_ERR;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Byte-stream program loader writing 16-bit words into instruction memory.
// Holds the CPU until a frame with a good checksum has been loaded.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter logic [7:0] SYNC_BYTE = DEF_SYNC,
  parameter int         MAX_WORDS = DEF_MAX_WORDS,
  parameter int         ADDR_W    = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [15:0]       imem_wdata,
  output logic              cpu_hold,
  output logic              done,
  output logic              error
);

  logic              acc;
  logic              wr;
  logic [ADDR_W-2:0] idx;
  logic [7:0]        lo;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [15:0]       wdata_q;

  // The write cycle is the single bubble: no byte is taken while we_q is high.
  assign in_ready   = rst_n & ~we_q;
  assign acc        = in_valid & in_ready;
  assign imem_we    = we_q & rst_n;
  assign imem_addr  = addr_q;
  assign imem_wdata = wdata_q;

  loader_fsm #(
    .SYNC_BYTE (SYNC_BYTE),
    .MAX_WORDS (MAX_WORDS),
    .IDX_W     (ADDR_W - 1)
  ) u_fsm (
    .clk     (clk),
    .rst_n   (rst_n),
    .byte_i  (in_data),
    .acc_i   (acc),
    .wr_o    (wr),
    .idx_o   (idx),
    .lo_o    (lo),
    .done_o  (done),
    .error_o (error),
    .hold_o  (cpu_hold)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      we_q <= wr;
      if (wr) begin
        addr_q  <= {idx, 1'b0};
        wdata_q <= {in_data, lo};
      end
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Randomized bench for imem_loader: frames are built here and
// expected writes/status derived from the frame contents.
module tb_imem_loader;
  import imem_loader_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        imem_we;
  logic [15:0] imem_addr;
  logic [15:0] imem_wdata;
  logic        cpu_hold;
  logic        done;
  logic        error;

  int errs = 0;
  int checks = 0;
  int nwr = 0;
  logic [15:0] wq[$];

  imem_loader dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .cpu_hold   (cpu_hold),
    .done       (done),
    .error      (error)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (imem_we) nwr++;
    chk("rdy", {31'd0, in_ready}, {31'd0, rst_n & ~imem_we});
  end

  task automatic send(input logic [7:0] b, input bit wr,
                      input logic [15:0] a, input logic [15:0] d);
    int t = 0;
    repeat ($urandom_range(0, 2)) begin
      @(negedge clk);
      in_valid = 1'b0;
      in_data  = 8'($urandom);
    end
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = b;
    while (!in_ready && t < 20) begin
      @(negedge clk);
      t++;
    end
    if (t >= 20) begin
      chk("timeout", 0, 1);
      in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_data  = 8'($urandom);
    if (wr) begin
      chk("we", {31'd0, imem_we}, 1);
      chk("addr", {16'd0, imem_addr}, {16'd0, a});
      chk("wdata", {16'd0, imem_wdata}, {16'd0, d});
      chk("bubble", {31'd0, in_ready}, 0);
    end else begin
      chk("we_idle", {31'd0, imem_we}, 0);
    end
  endtask

  task automatic frame(input logic [15:0] len, input logic [7:0] flip);
    logic [7:0] c = 8'h00;
    bit okl = (len != 0) && (len <= 16'(DEF_MAX_WORDS));
    int w0 = nwr;
    send(DEF_SYNC, 0, 0, 0);
    send(len[7:0], 0, 0, 0);
    send(len[15:8], 0, 0, 0);
    if (!okl) begin
      chk("len_err", {31'd0, error}, 1);
      chk("len_done", {31'd0, done}, 0);
      chk("len_hold", {31'd0, cpu_hold}, 1);
      chk("len_nwr", nwr - w0, 0);
      return;
    end
    foreach (wq[i]) begin
      send(wq[i][7:0], 0, 0, 0);
      send(wq[i][15:8], 1, 16'(2 * i), wq[i]);
      c = c ^ wq[i][7:0] ^ wq[i][15:8];
    end
    send(c ^ flip, 0, 0, 0);
    chk("done", {31'd0, done}, {31'd0, flip == 0});
    chk("error", {31'd0, error}, {31'd0, flip != 0});
    chk("hold", {31'd0, cpu_hold}, {31'd0, flip != 0});
    chk("nwr", nwr - w0, wq.size());
  endtask

  initial begin
    int w;
    int n;
    logic [7:0] f;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_we", {31'd0, imem_we}, 0);
    chk("rst_rdy", {31'd0, in_ready}, 0);
    chk("rst_hold", {31'd0, cpu_hold}, 1);
    chk("rst_done", {31'd0, done}, 0);
    chk("rst_err", {31'd0, error}, 0);
    chk("rst_addr", {16'd0, imem_addr}, 0);
    chk("rst_wdata", {16'd0, imem_wdata}, 0);
    @(posedge clk);
    #2 rst_n = 1'b1;

    wq = '{16'h1234, 16'h5678};
    frame(16'd2, 8'h00);
    frame(16'd2, 8'h01);

    wq = {};
    frame(16'd0, 8'h00);
    frame(16'd257, 8'h00);

    send(8'h00, 0, 0, 0);
    send(8'hFF, 0, 0, 0);
    chk("drop_err", {31'd0, error}, 1);
    wq = '{16'h1234, 16'h5678};
    frame(16'd2, 8'h00);
    send(8'h3C, 0, 0, 0);
    chk("drop_done", {31'd0, done}, 1);

    send(DEF_SYNC, 0, 0, 0);
    send(8'h02, 0, 0, 0);
    send(8'h00, 0, 0, 0);
    send(8'h34, 0, 0, 0);
    send(8'h12, 1, 16'h0000, 16'h1234);
    send(8'h78, 0, 0, 0);
    @(posedge clk);
    #2 rst_n = 1'b0;
    w = nwr;
    @(negedge clk);
    chk("mrst_we", {31'd0, imem_we}, 0);
    chk("mrst_hold", {31'd0, cpu_hold}, 1);
    chk("mrst_done", {31'd0, done}, 0);
    @(posedge clk);
    #2 rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("mrst_nwr", nwr - w, 0);
    chk("mrst_hold2", {31'd0, cpu_hold}, 1);
    frame(16'd2, 8'h00);

    for (int k = 0; k < 12; k++) begin
      n = $urandom_range(1, 8);
      wq = {};
      for (int j = 0; j < n; j++) wq.push_back(16'($urandom));
      f = ($urandom_range(0, 2) == 0) ? 8'($urandom_range(1, 255)) : 8'h00;
      frame(16'(n), f);
    end

    wq = {};
    for (int j = 0; j < DEF_MAX_WORDS; j++) wq.push_back(16'($urandom));
    frame(16'(DEF_MAX_WORDS), 8'h00);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
